// File: rtl/ttt_match_controller_if.sv
// Request/grant and board-control bundle between the match sequencer and its players/board.
// The master side drives player requests and board status; the slave side is the controller.
interface ttt_match_controller_if;
    logic       start;
    logic       o_req_valid;
    logic [3:0] o_req_pos;
    logic       o_req_ready;
    logic       x_req_valid;
    logic [3:0] x_req_pos;
    logic       x_req_ready;
    logic [8:0] occ_mask;
    logic [1:0] game_result;
    logic       board_clr;
    logic       board_wr_en;
    logic [3:0] board_wr_pos;
    logic [1:0] board_wr_sym;
    logic [1:0] turn;
    logic [2:0] state;
    logic       illegal_move;
    logic       timeout;
    logic [3:0] o_score;
    logic [3:0] x_score;
    logic [3:0] round_num;
    logic       match_done;
    logic [1:0] match_winner;

    modport master (
        output start, o_req_valid, o_req_pos, x_req_valid, x_req_pos, occ_mask, game_result,
        input  o_req_ready, x_req_ready, board_clr, board_wr_en, board_wr_pos, board_wr_sym,
        input  turn, state, illegal_move, timeout, o_score, x_score, round_num,
        input  match_done, match_winner
    );

    modport slave (
        input  start, o_req_valid, o_req_pos, x_req_valid, x_req_pos, occ_mask, game_result,
        output o_req_ready, x_req_ready, board_clr, board_wr_en, board_wr_pos, board_wr_sym,
        output turn, state, illegal_move, timeout, o_score, x_score, round_num,
        output match_done, match_winner
    );
endinterface

// File: rtl/ttt_match_controller.sv
// Tic-tac-toe match sequencer: grants turns, validates moves, skips idle players, keeps round scores.
// Every output is registered from next-state values, so outputs line up with the state they describe.
module ttt_match_controller #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 10,
    parameter int WINS_NEEDED    = 2,
    parameter int MAX_ROUNDS     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    ttt_match_controller_if.slave mif
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        WAIT_MOVE  = 3'd2,
        WRITE      = 3'd3,
        CHECK      = 3'd4,
        ROUND_END  = 3'd5,
        MATCH_OVER = 3'd6
    } state_t;

    localparam logic [1:0]         SYM_NONE   = 2'b00;
    localparam logic [1:0]         SYM_O      = 2'b01;
    localparam logic [1:0]         SYM_X      = 2'b10;
    localparam logic [1:0]         SYM_TIE    = 2'b11;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         WINS       = 4'(WINS_NEEDED);
    localparam logic [4:0]         ROUNDS     = 5'(MAX_ROUNDS);

    state_t             state_q, state_d;
    logic [1:0]         turn_q, turn_d;
    logic [1:0]         starter_q, starter_d;
    logic [1:0]         result_q, result_d;
    logic [1:0]         winner_q, winner_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         pos_q, pos_d;
    logic [3:0]         o_score_q, o_score_d;
    logic [3:0]         x_score_q, x_score_d;
    logic [3:0]         round_q, round_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic               o_rdy_q, x_rdy_q, clr_q, wr_en_q, done_q;
    logic [3:0]         wr_pos_q;
    logic [1:0]         wr_sym_q;

    logic               o_hs, x_hs, hs, legal;
    logic [3:0]         req_pos, req_idx;

    // Readies are only ever high for the player on turn, so at most one handshake fires.
    assign o_hs    = mif.o_req_valid & o_rdy_q;
    assign x_hs    = mif.x_req_valid & x_rdy_q;
    assign hs      = o_hs | x_hs;
    assign req_pos = o_hs ? mif.o_req_pos : mif.x_req_pos;
    assign req_idx = req_pos - 4'd1;
    assign legal   = (req_pos != 4'd0) && (req_pos <= 4'd9) && !mif.occ_mask[req_idx];

    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        starter_d = starter_q;
        result_d  = result_q;
        winner_d  = winner_q;
        timer_d   = timer_q;
        pos_d     = pos_q;
        o_score_d = o_score_q;
        x_score_d = x_score_q;
        round_d   = round_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (mif.start) begin
                    state_d   = CLEAR;
                    o_score_d = 4'd0;
                    x_score_d = 4'd0;
                    round_d   = 4'd0;
                    starter_d = SYM_O;
                    winner_d  = SYM_NONE;
                end
            end
            CLEAR: begin
                timer_d = '0;
                state_d = WAIT_MOVE;
            end
            WAIT_MOVE: begin
                if (hs && legal) begin
                    pos_d   = req_pos;
                    state_d = WRITE;
                end else if (hs) begin
                    // A rejected attempt still burns turn time; hold at the limit so expiry is not lost.
                    illegal_d = 1'b1;
                    timer_d   = (timer_q >= TIMER_LAST) ? timer_q : timer_q + 1'b1;
                end else if (timer_q >= TIMER_LAST) begin
                    timeout_d = 1'b1;
                    turn_d    = turn_q ^ 2'b11;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WRITE: begin
                state_d = CHECK;
            end
            CHECK: begin
                result_d = mif.game_result;
                if (mif.game_result == SYM_NONE) begin
                    turn_d  = turn_q ^ 2'b11;
                    timer_d = '0;
                    state_d = WAIT_MOVE;
                end else begin
                    state_d = ROUND_END;
                end
            end
            ROUND_END: begin
                if (result_q == SYM_O && o_score_q != 4'hF) o_score_d = o_score_q + 4'd1;
                if (result_q == SYM_X && x_score_q != 4'hF) x_score_d = x_score_q + 4'd1;
                if (round_q != 4'hF) round_d = round_q + 4'd1;
                starter_d = starter_q ^ 2'b11;
                if (o_score_d == WINS || x_score_d == WINS || ({1'b0, round_q} + 5'd1) == ROUNDS) begin
                    state_d  = MATCH_OVER;
                    winner_d = (o_score_d > x_score_d) ? SYM_O :
                               (x_score_d > o_score_d) ? SYM_X : SYM_TIE;
                end else begin
                    state_d = CLEAR;
                end
            end
            MATCH_OVER: begin
                if (mif.start) begin
                    state_d   = CLEAR;
                    o_score_d = 4'd0;
                    x_score_d = 4'd0;
                    round_d   = 4'd0;
                    starter_d = SYM_O;
                    winner_d  = SYM_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Turn is shown from the clear cycle onward and blanked whenever no round is in play.
        if (state_d == CLEAR) begin
            turn_d = starter_d;
        end else if (state_d == IDLE || state_d == ROUND_END || state_d == MATCH_OVER) begin
            turn_d = SYM_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            turn_q    <= SYM_NONE;
            starter_q <= SYM_O;
            result_q  <= SYM_NONE;
            winner_q  <= SYM_NONE;
            timer_q   <= '0;
            pos_q     <= 4'd0;
            o_score_q <= 4'd0;
            x_score_q <= 4'd0;
            round_q   <= 4'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            o_rdy_q   <= 1'b0;
            x_rdy_q   <= 1'b0;
            clr_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_pos_q  <= 4'd0;
            wr_sym_q  <= SYM_NONE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            starter_q <= starter_d;
            result_q  <= result_d;
            winner_q  <= winner_d;
            timer_q   <= timer_d;
            pos_q     <= pos_d;
            o_score_q <= o_score_d;
            x_score_q <= x_score_d;
            round_q   <= round_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            o_rdy_q   <= (state_d == WAIT_MOVE) && (turn_d == SYM_O);
            x_rdy_q   <= (state_d == WAIT_MOVE) && (turn_d == SYM_X);
            clr_q     <= (state_d == CLEAR);
            wr_en_q   <= (state_d == WRITE);
            wr_pos_q  <= (state_d == WRITE) ? pos_d : 4'd0;
            wr_sym_q  <= (state_d == WRITE) ? turn_d : SYM_NONE;
            done_q    <= (state_d == MATCH_OVER);
        end
    end

    assign mif.o_req_ready  = o_rdy_q;
    assign mif.x_req_ready  = x_rdy_q;
    assign mif.board_clr    = clr_q;
    assign mif.board_wr_en  = wr_en_q;
    assign mif.board_wr_pos = wr_pos_q;
    assign mif.board_wr_sym = wr_sym_q;
    assign mif.turn         = turn_q;
    assign mif.state        = state_q;
    assign mif.illegal_move = illegal_q;
    assign mif.timeout      = timeout_q;
    assign mif.o_score      = o_score_q;
    assign mif.x_score      = x_score_q;
    assign mif.round_num    = round_q;
    assign mif.match_done   = done_q;
    assign mif.match_winner = winner_q;
endmodule

// File: tb/tb_ttt_match_controller.sv
// Directed bench for the match sequencer: a behavioural 3x3 board answers writes/clears and
// reports occupancy and the win/draw status that the controller samples.
module tb_ttt_match_controller;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    ttt_match_controller_if mif ();

    ttt_match_controller #(
        .TIMEOUT_CYCLES(8),
        .TIMER_W       (4),
        .WINS_NEEDED   (2),
        .MAX_ROUNDS    (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mif  (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board model: cell k lives in cells[2k+1:2k].
    logic [17:0] cells;

    always @(posedge clk) begin
        if (reset || mif.board_clr) begin
            cells <= 18'd0;
        end else if (mif.board_wr_en && mif.board_wr_pos >= 4'd1 && mif.board_wr_pos <= 4'd9) begin
            cells[2*(int'(mif.board_wr_pos) - 1) +: 2] <= mif.board_wr_sym;
        end
    end

    function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
    endfunction

    function automatic logic [1:0] eval_board(input logic [17:0] c);
        logic [1:0] r;
        logic       full;
        r = line3(c[1:0], c[3:2], c[5:4]) | line3(c[7:6], c[9:8], c[11:10]) |
            line3(c[13:12], c[15:14], c[17:16]) | line3(c[1:0], c[7:6], c[13:12]) |
            line3(c[3:2], c[9:8], c[15:14]) | line3(c[5:4], c[11:10], c[17:16]) |
            line3(c[1:0], c[9:8], c[17:16]) | line3(c[5:4], c[9:8], c[13:12]);
        full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (c[2*k +: 2] == 2'b00) full = 1'b0;
        end
        if (r == 2'b00 && full) r = 2'b11;
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < 9; k++) mif.occ_mask[k] = (cells[2*k +: 2] != 2'b00);
    end
    assign mif.game_result = eval_board(cells);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the player's ready, offers one request, then checks the WRITE cycle.
    task automatic move(input logic is_x, input logic [3:0] pos, input string tag);
        int n;
        n = 0;
        while (((is_x ? mif.x_req_ready : mif.o_req_ready) !== 1'b1) && (n < 40)) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 32'(is_x ? mif.x_req_ready : mif.o_req_ready), 1);
        if (is_x) begin
            mif.x_req_valid = 1'b1;
            mif.x_req_pos   = pos;
        end else begin
            mif.o_req_valid = 1'b1;
            mif.o_req_pos   = pos;
        end
        tick();
        mif.o_req_valid = 1'b0;
        mif.x_req_valid = 1'b0;
        chk({tag, "_wr"}, 32'(mif.board_wr_en), 1);
        chk({tag, "_pos"}, 32'(mif.board_wr_pos), 32'(pos));
        chk({tag, "_sym"}, 32'(mif.board_wr_sym), is_x ? 2 : 1);
    endtask

    // From the WRITE cycle of a round's final move: CHECK, ROUND_END, then the following state.
    task automatic end_round(input string tag);
        tick();
        tick();
        chk({tag, "_round_end"}, 32'(mif.state), 5);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        reset           = 1'b1;
        mif.start       = 1'b0;
        mif.o_req_valid = 1'b0;
        mif.o_req_pos   = 4'd0;
        mif.x_req_valid = 1'b0;
        mif.x_req_pos   = 4'd0;
        repeat (3) tick();
        chk("rst_state", 32'(mif.state), 0);
        chk("rst_turn", 32'(mif.turn), 0);
        chk("rst_rdy", 32'({mif.o_req_ready, mif.x_req_ready}), 0);
        chk("rst_done", 32'({mif.match_done, mif.match_winner}), 0);
        chk("rst_scores", 32'({mif.o_score, mif.x_score, mif.round_num}), 0);
        reset = 1'b0;
        tick();
        chk("idle_hold", 32'(mif.state), 0);

        // Match 1, round 1: O starts.
        mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        chk("clr_state", 32'(mif.state), 1);
        chk("clr_pulse", 32'(mif.board_clr), 1);
        chk("clr_turn", 32'(mif.turn), 1);
        tick();
        chk("wait_state", 32'(mif.state), 2);
        chk("clr_once", 32'(mif.board_clr), 0);
        chk("rdy_o_first", 32'({mif.o_req_ready, mif.x_req_ready}), 2);
        move(1'b0, 4'd1, "r1_o1");
        tick();
        chk("lat_check", 32'(mif.state), 4);
        chk("lat_rdy_check", 32'({mif.o_req_ready, mif.x_req_ready}), 0);
        tick();
        chk("lat_wait", 32'(mif.state), 2);
        chk("lat_x_rdy", 32'({mif.o_req_ready, mif.x_req_ready}), 1);
        chk("lat_turn", 32'(mif.turn), 2);
        move(1'b1, 4'd4, "r1_x4");
        move(1'b0, 4'd2, "r1_o2");
        move(1'b1, 4'd5, "r1_x5");
        tick();
        tick();
        chk("ill_pre_turn", 32'(mif.turn), 1);

        // Occupied cell 5, then out-of-range 0 and 10.
        mif.o_req_valid = 1'b1;
        mif.o_req_pos   = 4'd5;
        tick();
        chk("ill_occupied", 32'(mif.illegal_move), 1);
        chk("ill_occ_no_wr", 32'(mif.board_wr_en), 0);
        mif.o_req_pos = 4'd0;
        tick();
        chk("ill_zero", 32'(mif.illegal_move), 1);
        mif.o_req_pos = 4'd10;
        tick();
        chk("ill_ten", 32'(mif.illegal_move), 1);
        chk("ill_no_wr", 32'(mif.board_wr_en), 0);
        chk("ill_turn", 32'(mif.turn), 1);
        chk("ill_state", 32'(mif.state), 2);
        mif.o_req_valid = 1'b0;
        tick();
        chk("ill_clear", 32'(mif.illegal_move), 0);
        chk("ill_rdy", 32'(mif.o_req_ready), 1);

        // Both players request on O's turn; only O is taken.
        mif.o_req_valid = 1'b1;
        mif.o_req_pos   = 4'd3;
        mif.x_req_valid = 1'b1;
        mif.x_req_pos   = 4'd9;
        chk("both_x_rdy", 32'(mif.x_req_ready), 0);
        tick();
        mif.o_req_valid = 1'b0;
        mif.x_req_valid = 1'b0;
        chk("both_wr", 32'(mif.board_wr_en), 1);
        chk("both_sym", 32'(mif.board_wr_sym), 1);
        chk("both_pos", 32'(mif.board_wr_pos), 3);
        end_round("r1");
        chk("r1_clr_state", 32'(mif.state), 1);
        chk("r1_clr_pulse", 32'(mif.board_clr), 1);
        chk("r1_next_turn", 32'(mif.turn), 2);
        chk("r1_scores", 32'({mif.o_score, mif.x_score, mif.round_num}), 32'h101);

        // Round 2: X starts and idles into a timeout, O then moves on the last allowed cycle.
        tick();
        chk("r2_x_rdy", 32'({mif.o_req_ready, mif.x_req_ready}), 1);
        repeat (7) tick();
        chk("to_not_early", 32'(mif.timeout), 0);
        chk("to_turn_hold", 32'(mif.turn), 2);
        tick();
        chk("to_pulse", 32'(mif.timeout), 1);
        chk("to_turn", 32'(mif.turn), 1);
        chk("to_rdy", 32'({mif.o_req_ready, mif.x_req_ready}), 2);
        tick();
        chk("to_once", 32'(mif.timeout), 0);
        repeat (6) tick();
        move(1'b0, 4'd5, "r2_o5_late");
        chk("late_no_to", 32'(mif.timeout), 0);
        move(1'b1, 4'd2, "r2_x2");
        move(1'b0, 4'd1, "r2_o1");
        move(1'b1, 4'd4, "r2_x4");
        move(1'b0, 4'd3, "r2_o3");
        move(1'b1, 4'd7, "r2_x7");
        move(1'b0, 4'd6, "r2_o6");
        move(1'b1, 4'd9, "r2_x9");
        move(1'b0, 4'd8, "r2_o8");
        end_round("r2");
        chk("r2_clr_state", 32'(mif.state), 1);
        chk("r2_next_turn", 32'(mif.turn), 1);
        chk("r2_scores", 32'({mif.o_score, mif.x_score, mif.round_num}), 32'h102);

        // Round 3: X wins on row 4-5-6; the round limit closes the match tied.
        move(1'b0, 4'd1, "r3_o1");
        move(1'b1, 4'd4, "r3_x4");
        move(1'b0, 4'd2, "r3_o2");
        move(1'b1, 4'd5, "r3_x5");
        move(1'b0, 4'd7, "r3_o7");
        move(1'b1, 4'd6, "r3_x6");
        end_round("r3");
        chk("m1_over_state", 32'(mif.state), 6);
        chk("m1_done", 32'(mif.match_done), 1);
        chk("m1_winner", 32'(mif.match_winner), 3);
        chk("m1_scores", 32'({mif.o_score, mif.x_score, mif.round_num}), 32'h113);
        chk("m1_turn_idle", 32'({mif.turn, mif.o_req_ready, mif.x_req_ready}), 0);
        tick();
        chk("m1_hold", 32'({mif.state, mif.match_winner}), 32'b11011);

        // Match 2: O takes two rounds.
        mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        chk("m2_clr_state", 32'(mif.state), 1);
        chk("m2_scores_clr", 32'({mif.o_score, mif.x_score, mif.round_num}), 0);
        chk("m2_done_clr", 32'({mif.match_done, mif.match_winner}), 0);
        chk("m2_turn", 32'(mif.turn), 1);
        move(1'b0, 4'd1, "m2r1_o1");
        move(1'b1, 4'd4, "m2r1_x4");
        move(1'b0, 4'd2, "m2r1_o2");
        move(1'b1, 4'd5, "m2r1_x5");
        move(1'b0, 4'd3, "m2r1_o3");
        end_round("m2r1");
        chk("m2r1_scores", 32'({mif.o_score, mif.x_score, mif.round_num}), 32'h101);
        chk("m2r1_turn", 32'(mif.turn), 2);
        move(1'b1, 4'd1, "m2r2_x1");
        move(1'b0, 4'd4, "m2r2_o4");
        move(1'b1, 4'd2, "m2r2_x2");
        move(1'b0, 4'd5, "m2r2_o5");
        move(1'b1, 4'd9, "m2r2_x9");
        move(1'b0, 4'd6, "m2r2_o6");
        end_round("m2r2");
        chk("m2_over_state", 32'(mif.state), 6);
        chk("m2_winner", 32'(mif.match_winner), 1);
        chk("m2_scores", 32'({mif.o_score, mif.x_score, mif.round_num}), 32'h202);

        // Reset landing in a WRITE cycle.
        mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        move(1'b0, 4'd1, "rw_o1");
        chk("rw_in_write", 32'(mif.state), 3);
        reset = 1'b1;
        tick();
        chk("rw_state", 32'(mif.state), 0);
        chk("rw_board", 32'({mif.board_wr_en, mif.board_clr, mif.board_wr_pos, mif.board_wr_sym}), 0);
        chk("rw_turn_rdy", 32'({mif.turn, mif.o_req_ready, mif.x_req_ready}), 0);
        chk("rw_scores", 32'({mif.o_score, mif.x_score, mif.round_num}), 0);
        chk("rw_flags", 32'({mif.match_done, mif.match_winner, mif.illegal_move, mif.timeout}), 0);
        reset = 1'b0;
        tick();
        mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        chk("rw_restart_clr", 32'(mif.board_clr), 1);
        chk("rw_restart_turn", 32'(mif.turn), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
